// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI transfer sequencer:
//               state encoding, SPI mode codes and frame/divisor defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_t;

    // spi_mode codes; any other value means stop
    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;

    // Default frame width and the smallest usable sclk divisor
    localparam int SPI_DATA_BITS = 8;
    localparam int SPI_MIN_DIV   = 2;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : Master-side SPI transfer sequencer. Drops slave select on a
//               send request, gates the frame for DATA_BITS sclk periods of
//               the captured baud divisor, then pulses receive_data. Aborts
//               the frame if the core becomes inactive mid-transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_BITS = SPI_DATA_BITS,
    parameter int DIV_W     = 12,
    parameter int CNT_W     = 16
) (
    input  logic             Pclk,
    input  logic             PRESET,
    input  logic             spe,
    input  logic             mstr,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             send_data,
    input  logic [DIV_W-1:0] BaudRateDivisor,
    output logic             ss,
    output logic             tip,
    output logic             receive_data,
    output logic             abort
);

    // Frame length multiplier, smallest divisor, and counter step
    localparam logic [CNT_W-1:0] c_frame_bits = CNT_W'(DATA_BITS);
    localparam logic [DIV_W-1:0] c_min_div    = DIV_W'(SPI_MIN_DIV);
    localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};

    spi_state_t       r_state;
    spi_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic             r_ss;
    logic             r_tip;
    logic             r_rx;
    logic             r_abort;

    logic             w_active;
    logic [DIV_W-1:0] w_div_capt;
    logic [CNT_W-1:0] w_target;
    logic             w_terminal;
    logic             w_ss_nxt;
    logic             w_tip_nxt;
    logic             w_rx_nxt;
    logic             w_abort_nxt;

    // Core is live in run mode, or in wait mode while SPI clocks keep running
    assign w_active = spe & mstr &
                      ((spi_mode == SPI_RUN) | ((spi_mode == SPI_WAIT) & ~spiswai));

    // Divisors below the minimum cannot produce an sclk, so clamp them
    assign w_div_capt = (BaudRateDivisor < c_min_div) ? c_min_div : BaudRateDivisor;

    // Frame length in Pclk cycles; the last SHIFT cycle has count target-1
    assign w_target   = c_frame_bits * {{(CNT_W-DIV_W){1'b0}}, r_div_q};
    assign w_terminal = (r_cnt == (w_target - c_cnt_one));

    // Next state and next registered outputs; outputs track the state entered
    always_comb begin
        w_state_nxt = r_state;
        w_ss_nxt    = 1'b1;
        w_tip_nxt   = 1'b0;
        w_rx_nxt    = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_data && w_active) begin
                    w_state_nxt = ST_LOAD;
                    w_ss_nxt    = 1'b0;
                    w_tip_nxt   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                    w_ss_nxt    = 1'b0;
                    w_tip_nxt   = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Losing the active condition wins over frame completion
                if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_nxt = 1'b1;
                end else if (w_terminal) begin
                    w_state_nxt = ST_DONE;
                    w_rx_nxt    = 1'b1;
                end else begin
                    w_ss_nxt    = 1'b0;
                    w_tip_nxt   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Pclk) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_ss    <= 1'b1;
            r_tip   <= 1'b0;
            r_rx    <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ss    <= w_ss_nxt;
            r_tip   <= w_tip_nxt;
            r_rx    <= w_rx_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // Divisor capture and frame cycle counter
    always_ff @(posedge Pclk) begin
        if (PRESET) begin
            r_cnt   <= '0;
            r_div_q <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_div_q <= w_div_capt;
                    r_cnt   <= '0;
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ss           = r_ss;
    assign tip          = r_tip;
    assign receive_data = r_rx;
    assign abort        = r_abort;

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_ctrl
// Description : Self-checking bench for spi_xfer_ctrl. A cycle-level frame
//               model predicts every output; measured ss-low windows are also
//               pinned against hand-computed lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

    logic        clk;
    logic        rst;
    logic        spe;
    logic        mstr;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic        send;
    logic [11:0] div;
    logic        ss;
    logic        tip;
    logic        rx;
    logic        ab;

    int errs   = 0;
    int checks = 0;

    spi_xfer_ctrl #(
        .DATA_BITS (8),
        .DIV_W     (12),
        .CNT_W     (16)
    ) u_dut (
        .Pclk            (clk),
        .PRESET          (rst),
        .spe             (spe),
        .mstr            (mstr),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .send_data       (send),
        .BaudRateDivisor (div),
        .ss              (ss),
        .tip             (tip),
        .receive_data    (rx),
        .abort           (ab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_active(input logic e, input logic m,
                                        input logic [1:0] md, input logic sw);
        return e && m && (md == 2'b00 || (md == 2'b01 && !sw));
    endfunction

    // Frame model: m_el counts ss-low cycles so far, m_len is the full
    // ss-low length (1 + 8*divisor), known once the divisor is captured.
    bit m_valid = 1'b0;
    bit m_busy, m_cool, m_rx, m_ab;
    int m_el, m_len;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_cool  <= 1'b0;
            m_rx    <= 1'b0;
            m_ab    <= 1'b0;
            m_el    <= 0;
            m_len   <= 0;
        end else begin
            m_rx <= 1'b0;
            m_ab <= 1'b0;
            if (m_cool) begin
                m_cool <= 1'b0;
            end else if (!m_busy) begin
                if (send && model_active(spe, mstr, spi_mode, spiswai)) begin
                    m_busy <= 1'b1;
                    m_el   <= 1;
                    m_len  <= 0;
                end
            end else if (!model_active(spe, mstr, spi_mode, spiswai)) begin
                m_busy <= 1'b0;
                m_ab   <= 1'b1;
            end else if (m_len == 0) begin
                m_len <= 1 + 8 * ((div < 12'd2) ? 2 : int'(div));
                m_el  <= 2;
            end else if (m_el == m_len) begin
                m_busy <= 1'b0;
                m_rx   <= 1'b1;
                m_cool <= 1'b1;
            end else begin
                m_el <= m_el + 1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ss",           int'(ss),  int'(!m_busy));
            chk("tip",          int'(tip), int'(m_busy));
            chk("receive_data", int'(rx),  int'(m_rx));
            chk("abort",        int'(ab),  int'(m_ab));
            chk("rx_ab_excl",   int'(rx && ab), 0);
        end
    end

    // Window monitor: ss-low run lengths, preceding gaps and pulse counts
    int win_q[$];
    int low_run = 0, high_run = 0, last_gap = 0, rx_cnt = 0, ab_cnt = 0;
    bit prev_ss = 1'b1;

    always @(negedge clk) begin
        if (ss === 1'b0) begin
            if (prev_ss) last_gap = high_run;
            low_run  = low_run + 1;
            high_run = 0;
        end else begin
            if (!prev_ss) win_q.push_back(low_run);
            low_run  = 0;
            high_run = high_run + 1;
        end
        prev_ss = (ss !== 1'b0);
        if (rx === 1'b1) rx_cnt++;
        if (ab === 1'b1) ab_cnt++;
    end

    int b_w, b_rx, b_ab;

    task automatic snap();
        b_w  = win_q.size();
        b_rx = rx_cnt;
        b_ab = ab_cnt;
    endtask

    task automatic frame_pulse();
        @(negedge clk) send = 1'b1;
        @(negedge clk) send = 1'b0;
    endtask

    task automatic expect_frames(input string name, input int nwin, input int len,
                                 input int nrx, input int nab);
        chk({name, "_windows"}, win_q.size() - b_w, nwin);
        chk({name, "_len"},     (win_q.size() > 0) ? win_q[$] : -1, len);
        chk({name, "_rx"},      rx_cnt - b_rx, nrx);
        chk({name, "_abort"},   ab_cnt - b_ab, nab);
    endtask

    // Kill or keep a frame by changing mode while SHIFT count is 10
    task automatic mode_case(input string name, input logic [1:0] md, input logic sw,
                             input bit kills);
        div = 12'd4;
        snap();
        frame_pulse();
        repeat (11) @(negedge clk);
        spi_mode = md;
        spiswai  = sw;
        @(negedge clk);
        spi_mode = 2'b00;
        spiswai  = 1'b0;
        repeat (40) @(negedge clk);
        if (kills) expect_frames(name, 1, 12, 0, 1);
        else       expect_frames(name, 1, 33, 1, 0);
    endtask

    initial begin
        rst = 1'b1; spe = 1'b0; mstr = 1'b0; spi_mode = 2'b00;
        spiswai = 1'b0; send = 1'b0; div = 12'd4;
        repeat (3) @(negedge clk);
        chk("reset_ss",  int'(ss),  1);
        chk("reset_tip", int'(tip), 0);
        chk("reset_rx",  int'(rx),  0);
        chk("reset_ab",  int'(ab),  0);
        rst = 1'b0; spe = 1'b1; mstr = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, divisor 4 -> 33 low cycles
        div = 12'd4;
        snap();
        frame_pulse();
        repeat (40) @(negedge clk);
        expect_frames("basic", 1, 33, 1, 0);

        // Divisor 0 clamps to 2 -> 17 low cycles
        div = 12'd0;
        snap();
        frame_pulse();
        repeat (30) @(negedge clk);
        expect_frames("div0", 1, 17, 1, 0);

        // Divisor 1 also clamps to 2
        div = 12'd1;
        snap();
        frame_pulse();
        repeat (30) @(negedge clk);
        expect_frames("div1", 1, 17, 1, 0);

        mode_case("stop_abort", 2'b10, 1'b0, 1'b1);
        mode_case("wait_swai",  2'b01, 1'b1, 1'b1);
        mode_case("wait_run",   2'b01, 1'b0, 1'b0);

        // Inactive when requested: no frame starts at all
        spe = 1'b0;
        snap();
        frame_pulse();
        repeat (5) @(negedge clk);
        chk("inactive_windows", win_q.size() - b_w, 0);
        spe = 1'b1;

        // Back-to-back frames with send held, divisor 2
        div = 12'd2;
        snap();
        @(negedge clk) send = 1'b1;
        repeat (20) @(negedge clk);
        send = 1'b0;
        repeat (40) @(negedge clk);
        expect_frames("b2b", 2, 17, 2, 0);
        chk("b2b_first_len", (win_q.size() > 1) ? win_q[win_q.size()-2] : -1, 17);
        chk("b2b_gap", last_gap, 2);

        // Divisor change mid-frame is ignored until the next frame
        div = 12'd4;
        snap();
        frame_pulse();
        repeat (3) @(negedge clk);
        div = 12'd16;
        repeat (40) @(negedge clk);
        expect_frames("divchg_cur", 1, 33, 1, 0);
        snap();
        frame_pulse();
        repeat (140) @(negedge clk);
        expect_frames("divchg_next", 1, 129, 1, 0);

        // Reset while SHIFT count is 5
        div = 12'd4;
        snap();
        frame_pulse();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_ss",  int'(ss),  1);
        chk("rst_mid_tip", int'(tip), 0);
        chk("rst_mid_rx",  int'(rx),  0);
        chk("rst_mid_ab",  int'(ab),  0);
        expect_frames("rst_mid", 1, 7, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        snap();
        frame_pulse();
        repeat (40) @(negedge clk);
        expect_frames("after_rst", 1, 33, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire
